aes_key_schedule: RTL and testbench

Sequential, parametrised AES key schedule engine supporting 128/192/256-bit cipher keys. It accepts a cipher key on a start strobe and generates the expanded key one 32-bit word per cycle using a single shared SubWord datapath. It streams the Nr+1 round keys in order over a valid/ready interface to the round datapath. It replaces the per-round combinational expansion with a multi-cycle generator that is shared across all round keys.

---
 rtl/aes_key_schedule.sv | 247 ++++++++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// AES key schedule engine (128/192/256-bit keys).
//
// Expands a cipher key one 32-bit word per cycle through a single shared SubWord datapath,
// then streams the Nr+1 round keys in order over a valid/ready handshake.
//
// Parameters:
//   KEY_BITS  cipher key size: 128, 192 or 256 (Nk = KEY_BITS/32, Nr = Nk+6)
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     one-cycle expansion request, honoured only while idle
//   key       cipher key, MSB-aligned (w[0] = key[255:224])
//   busy      expansion in progress
//   rk_valid  round key on rk/rk_idx is valid
//   rk_ready  consumer accepts on rk_valid && rk_ready
//   rk        round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
//   rk_idx    round index r
//   done      one-cycle pulse after round key Nr is accepted
// Optional feature, enabled by defining AES_KEY_SCHEDULE_STORE_EN:
//   rd_idx    round key read index
//   rd_key    stored round key at rd_idx, one cycle latency, 0 beyond Nr
module aes_key_schedule #(
  parameter int unsigned KEY_BITS = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         done
`ifdef AES_KEY_SCHEDULE_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  localparam int unsigned Nk        = KEY_BITS / 32;
  localparam int unsigned Nr        = Nk + 6;
  localparam logic [5:0]  LastWord  = 6'(4 * Nr + 3);
  localparam logic [3:0]  LastRound = 4'(Nr);
  localparam logic [2:0]  OldPos    = 3'(8 - Nk);  // window slot of w[i-Nk]
  localparam logic [2:0]  LastKcnt  = 3'(Nk - 1);
  localparam bit          Is256     = (Nk == 8);

  typedef enum logic [1:0] {StIdle, StLoad, StExpand, StDrain} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, which maps 0 to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] win_q [8];  // sliding window, win_q[7] = w[i-1]
  logic [31:0] win_d [8];
  logic [31:0] key_win [8];
  logic [5:0]  i_q, i_d;
  logic [3:0]  e_q, e_d;
  logic [2:0]  kcnt_q, kcnt_d;  // i mod Nk
  logic [7:0]  rcon_q, rcon_d;
  logic        rk_valid_q, rk_valid_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]  rk_idx_q, rk_idx_d;
  logic        done_q, done_d;

  logic [5:0]  e_words;
  logic [5:0]  ahead;
  logic [2:0]  base;
  logic        emit_phase, words_ready, accept, load_rk, gen, rot_sel;
  logic [31:0] t, sub_in, sub_out, t_new, w_new;
  logic [127:0] rk_next;

  // Key words are placed rotated so w[0] lands at slot 8-Nk; the slots below it are never
  // read before being shifted out.
  always_comb begin
    for (int p = 0; p < 8; p++) begin
      key_win[p] = key[255 - 32 * ((p + Nk) % 8) -: 32];
    end
  end

  assign e_words     = {e_q, 2'b00};
  assign ahead       = i_q - e_words;
  assign base        = 3'(6'd8 - ahead);
  assign emit_phase  = (state_q == StExpand) || (state_q == StDrain);
  assign words_ready = (e_words + 6'd3) < i_q;
  assign accept      = rk_valid_q && rk_ready;
  assign load_rk     = emit_phase && words_ready && (!rk_valid_q || accept);
  // Never run 8 or more words ahead of the emit index, or w[4e] would be shifted out.
  assign gen         = (state_q == StExpand) && (ahead < 6'd8);

  assign rk_next = {win_q[base], win_q[3'(base + 3'd1)], win_q[3'(base + 3'd2)],
                    win_q[3'(base + 3'd3)]};

  // Shared SubWord datapath
  assign t       = win_q[7];
  assign rot_sel = (kcnt_q == 3'd0);
  assign sub_in  = rot_sel ? {t[23:0], t[31:24]} : t;
  assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]),
                    sbox(sub_in[7:0])};

  always_comb begin
    t_new = t;
    if (rot_sel) begin
      t_new = sub_out ^ {rcon_q, 24'h0};
    end else if (Is256 && (kcnt_q == 3'd4)) begin
      t_new = sub_out;
    end
  end

  assign w_new = win_q[OldPos] ^ t_new;

  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    i_d        = i_q;
    e_d        = e_q;
    kcnt_d     = kcnt_q;
    rcon_d     = rcon_q;
    rk_valid_d = rk_valid_q;
    rk_d       = rk_q;
    rk_idx_d   = rk_idx_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_d   = key_win;
          state_d = StLoad;
        end
      end
      StLoad: begin
        i_d     = 6'(Nk);
        kcnt_d  = 3'd0;
        e_d     = 4'd0;
        rcon_d  = 8'h01;
        state_d = StExpand;
      end
      StExpand: begin
        if (gen) begin
          for (int p = 0; p < 7; p++) begin
            win_d[p] = win_q[p + 1];
          end
          win_d[7] = w_new;
          i_d      = i_q + 6'd1;
          kcnt_d   = (kcnt_q == LastKcnt) ? 3'd0 : kcnt_q + 3'd1;
          if (rot_sel) begin
            rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
          end
          if (i_q == LastWord) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (accept && (rk_idx_q == LastRound)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_rk) begin
      rk_valid_d = 1'b1;
      rk_d       = rk_next;
      rk_idx_d   = e_q;
      e_d        = e_q + 4'd1;
    end else if (accept) begin
      rk_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      i_q        <= '0;
      e_q        <= '0;
      kcnt_q     <= '0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
      rk_q       <= '0;
      rk_idx_q   <= '0;
      done_q     <= 1'b0;
      for (int p = 0; p < 8; p++) begin
        win_q[p] <= '0;
      end
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      i_q        <= i_d;
      e_q        <= e_d;
      kcnt_q     <= kcnt_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      rk_q       <= rk_d;
      rk_idx_q   <= rk_idx_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign rk_valid = rk_valid_q;
  assign rk       = rk_q;
  assign rk_idx   = rk_idx_q;
  assign done     = done_q;

`ifdef AES_KEY_SCHEDULE_STORE_EN
  // Storage deliberately has no reset so keys survive rst.
  logic [127:0] store_q [15];
  logic [127:0] rd_key_q;

  always_ff @(posedge clk) begin
    if (load_rk) begin
      store_q[e_q] <= rk_next;
    end
    rd_key_q <= (rd_idx <= LastRound) ? store_q[rd_idx] : '0;
  end

  assign rd_key = rd_key_q;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule: one instance per key size, table-driven known
// vectors, cycle-exact timing sequences, random keys with random backpressure checked against
// a FIPS-197 style reference expansion, and a mid-run reset sequence.
module tb_aes_key_schedule;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start_v [3];
  logic [255:0] key_v   [3];
  logic         ready_v [3];
  logic         busy_v  [3];
  logic         valid_v [3];
  logic [127:0] rk_v    [3];
  logic [3:0]   idx_v   [3];
  logic         done_v  [3];
`ifdef AES_KEY_SCHEDULE_STORE_EN
  logic [3:0]   rd_idx_v [3];
  logic [127:0] rd_key_v [3];
`endif

  aes_key_schedule #(.KEY_BITS(128)) u_ks128 (
    .clk(clk), .rst(rst), .start(start_v[0]), .key(key_v[0]), .busy(busy_v[0]),
    .rk_valid(valid_v[0]), .rk_ready(ready_v[0]), .rk(rk_v[0]), .rk_idx(idx_v[0]),
    .done(done_v[0])
`ifdef AES_KEY_SCHEDULE_STORE_EN
    , .rd_idx(rd_idx_v[0]), .rd_key(rd_key_v[0])
`endif
  );

  aes_key_schedule #(.KEY_BITS(192)) u_ks192 (
    .clk(clk), .rst(rst), .start(start_v[1]), .key(key_v[1]), .busy(busy_v[1]),
    .rk_valid(valid_v[1]), .rk_ready(ready_v[1]), .rk(rk_v[1]), .rk_idx(idx_v[1]),
    .done(done_v[1])
`ifdef AES_KEY_SCHEDULE_STORE_EN
    , .rd_idx(rd_idx_v[1]), .rd_key(rd_key_v[1])
`endif
  );

  aes_key_schedule #(.KEY_BITS(256)) u_ks256 (
    .clk(clk), .rst(rst), .start(start_v[2]), .key(key_v[2]), .busy(busy_v[2]),
    .rk_valid(valid_v[2]), .rk_ready(ready_v[2]), .rk(rk_v[2]), .rk_idx(idx_v[2]),
    .done(done_v[2])
`ifdef AES_KEY_SCHEDULE_STORE_EN
    , .rd_idx(rd_idx_v[2]), .rd_key(rd_key_v[2])
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: S-box from the generator walk, standard expansion loop.
  logic [7:0]  sb [256];
  logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                 8'h1b, 8'h36};
  logic [31:0] mw [60];

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
    logic [15:0] d;
    d = {v, v};
    return d[15 - s -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic model_expand(input int nk, input logic [255:0] k);
    logic [31:0] t;
    for (int j = 0; j < nk; j++) mw[j] = k[255 - 32 * j -: 32];
    for (int j = nk; j < 4 * (nk + 7); j++) begin
      t = mw[j - 1];
      if (j % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[j / nk - 1], 24'h0};
      else if (nk == 8 && j % nk == 4) t = subw(t);
      mw[j] = mw[j - nk] ^ t;
    end
  endtask

  function automatic int nk_of(input int w);
    return (w == 0) ? 4 : (w == 1) ? 6 : 8;
  endfunction

  // Results of the most recent run
  logic [127:0] cap     [16];
  logic [3:0]   cap_idx [16];
  int           cap_cyc [16];
  int ncap, done_cyc, done_cnt, stall_bad;
  logic busy_at_done, busy_after_start;

  // Cycle c = observation at the falling edge after rising edge T(c); start taken at T0.
  task automatic run_one(input int w, input logic [255:0] k, input bit rnd);
    bit           have_hold;
    logic [127:0] hold_rk;
    logic [3:0]   hold_idx;
    bit           rdy;
    ncap = 0; done_cyc = -1; done_cnt = 0; stall_bad = 0; have_hold = 0;
    for (int n = 0; n < 16; n++) begin
      cap[n] = '1; cap_idx[n] = 4'hf; cap_cyc[n] = -1;
    end
    @(negedge clk);
    key_v[w] = k; start_v[w] = 1'b1; ready_v[w] = 1'b1;
    @(negedge clk);
    start_v[w] = 1'b0; key_v[w] = '0;
    busy_after_start = busy_v[w];
    for (int c = 0; c < 400; c++) begin
      if (have_hold && (!valid_v[w] || rk_v[w] !== hold_rk || idx_v[w] !== hold_idx))
        stall_bad++;
      if (done_v[w]) begin
        if (done_cyc < 0) begin
          done_cyc = c; busy_at_done = busy_v[w];
        end
        done_cnt++;
      end
      if (done_cyc >= 0 && c > done_cyc + 2) break;
      // A second start mid-run must be ignored.
      if (c == 10) begin
        start_v[w] = 1'b1; key_v[w] = ~k;
      end else begin
        start_v[w] = 1'b0; key_v[w] = '0;
      end
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      ready_v[w] = rdy;
      if (valid_v[w] && rdy && ncap < 16) begin
        cap[ncap] = rk_v[w]; cap_idx[ncap] = idx_v[w]; cap_cyc[ncap] = c; ncap++;
      end
      have_hold = valid_v[w] && !rdy;
      hold_rk = rk_v[w]; hold_idx = idx_v[w];
      @(negedge clk);
    end
    ready_v[w] = 1'b0;
  endtask

  task automatic check_run(input int w, input logic [255:0] k, input string tag);
    int nr;
    nr = nk_of(w) + 6;
    model_expand(nk_of(w), k);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " key_count"}, ncap, nr + 1);
    for (int r = 0; r <= nr; r++) begin
      check($sformatf("%s rk%0d_idx", tag, r), cap_idx[r], r);
      check($sformatf("%s rk%0d", tag, r), cap[r],
            {mw[4 * r], mw[4 * r + 1], mw[4 * r + 2], mw[4 * r + 3]});
    end
    check({tag, " stall_stable"}, stall_bad, 0);
  endtask

  typedef struct {
    int           w;
    logic [255:0] key;
    int           r;
    logic [127:0] exp;
  } vec_t;

  localparam logic [255:0] KeyA = {128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 128'h0};
  localparam logic [255:0] KeyB = {192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b,
                                   64'h0};
  localparam logic [255:0] KeyC = 256'h603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4;

  initial begin
    vec_t vecs [8];
    logic [255:0] rkey;
    int w, pulses;
    bit found;

    vecs[0] = '{0, KeyA, 0,  128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
    vecs[1] = '{0, KeyA, 1,  128'ha0fafe17_88542cb1_23a33939_2a6c7605};
    vecs[2] = '{0, KeyA, 2,  128'hf2c295f2_7a96b943_5935807a_7359f67f};
    vecs[3] = '{0, KeyA, 10, 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6};
    vecs[4] = '{1, KeyB, 0,  128'h8e73b0f7_da0e6452_c810f32b_809079e5};
    vecs[5] = '{1, KeyB, 12, 128'he98ba06f_448c773c_8ecc7204_01002202};
    vecs[6] = '{2, KeyC, 1,  128'h1f352c07_3b6108d7_2d9810a3_0914dff4};
    vecs[7] = '{2, KeyC, 14, 128'hfe4890d1_e6188d0b_046df344_706c631e};

    build_sbox();
    for (int n = 0; n < 3; n++) begin
      start_v[n] = 1'b0; key_v[n] = '0; ready_v[n] = 1'b0;
`ifdef AES_KEY_SCHEDULE_STORE_EN
      rd_idx_v[n] = '0;
`endif
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      check($sformatf("reset busy[%0d]", n), busy_v[n], 0);
      check($sformatf("reset rk_valid[%0d]", n), valid_v[n], 0);
      check($sformatf("reset rk[%0d]", n), rk_v[n], 0);
      check($sformatf("reset rk_idx[%0d]", n), idx_v[n], 0);
      check($sformatf("reset done[%0d]", n), done_v[n], 0);
    end
    rst = 1'b0;

    // Known-answer table
    for (int v = 0; v < 8; v++) begin
      run_one(vecs[v].w, vecs[v].key, 1'b0);
      check($sformatf("vec%0d rk%0d", v, vecs[v].r), cap[vecs[v].r], vecs[v].exp);
    end

    // 128-bit, ready held high: exact timing
    run_one(0, KeyA, 1'b0);
    check_run(0, KeyA, "k128");
    check("k128 busy_after_start", busy_after_start, 1);
    check("k128 rk0_cycle", cap_cyc[0], 2);
    check("k128 rk1_cycle", cap_cyc[1], 6);
    check("k128 rk10_cycle", cap_cyc[10], 42);
    check("k128 done_cycle", done_cyc, 43);
    check("k128 busy_with_done", busy_at_done, 0);
`ifdef AES_KEY_SCHEDULE_STORE_EN
    @(negedge clk); rd_idx_v[0] = 4'd1;
    @(negedge clk);
    check("store rd1", rd_key_v[0], 128'ha0fafe17_88542cb1_23a33939_2a6c7605);
    rd_idx_v[0] = 4'd14;
    @(negedge clk);
    check("store rd14", rd_key_v[0], 0);
`endif

    // 192-bit order
    run_one(1, KeyB, 1'b0);
    check_run(1, KeyB, "k192");

    // 256-bit: rk0 and rk1 back to back from the loaded window
    run_one(2, KeyC, 1'b0);
    check_run(2, KeyC, "k256");
    check("k256 rk0_cycle", cap_cyc[0], 2);
    check("k256 rk1_cycle", cap_cyc[1], 3);

    // Random backpressure on the 128-bit vector
    run_one(0, KeyA, 1'b1);
    check_run(0, KeyA, "bp128");
    check("bp128 rk10_value", cap[10], 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6);

    // Random keys and backpressure on every key size
    for (int n = 0; n < 6; n++) begin
      w = n % 3;
      for (int j = 0; j < 8; j++) rkey[255 - 32 * j -: 32] = $urandom;
      run_one(w, rkey, 1'b1);
      check_run(w, rkey, $sformatf("rand%0d", n));
    end

    // Reset while rk_idx = 5
    @(negedge clk);
    key_v[0] = KeyA; start_v[0] = 1'b1; ready_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; key_v[0] = '0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (valid_v[0] && idx_v[0] == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("rst reached_idx5", found, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", busy_v[0], 0);
    check("rst rk_valid", valid_v[0], 0);
    check("rst rk_idx", idx_v[0], 0);
    check("rst done", done_v[0], 0);
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) pulses++;
    end
    check("rst no_done_no_busy", pulses, 0);
    ready_v[0] = 1'b0;
    for (int j = 0; j < 8; j++) rkey[255 - 32 * j -: 32] = $urandom;
    run_one(0, rkey, 1'b1);
    check_run(0, rkey, "after_rst");
    check("after_rst first_idx", cap_idx[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
